// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - N-digit multiplexed 7-segment scan driver with tear-free shadow update
// Optional feature macro: SSEG_LZ_BLANK_EN (leading-zero suppression on committed data).
module sseg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_BITS   = 16,
    parameter bit AN_ACT_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    output logic                    pending,
    output logic [0:6]              sseg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int                    IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACT_LOW}};

    logic [DIV_BITS-1:0]     presc;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    boundary;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [4*NUM_DIGITS-1:0] act_digits;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blank;

    logic [3:0]              nib [NUM_DIGITS];
    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   dark;
    logic [NUM_DIGITS-1:0]   onehot;

    function automatic logic [0:6] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b0000001;
            4'h1:    hex7 = 7'b1001111;
            4'h2:    hex7 = 7'b0010010;
            4'h3:    hex7 = 7'b0000110;
            4'h4:    hex7 = 7'b1001100;
            4'h5:    hex7 = 7'b0100100;
            4'h6:    hex7 = 7'b0100000;
            4'h7:    hex7 = 7'b0001111;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0000100;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b1100000;
            4'hC:    hex7 = 7'b0110001;
            4'hD:    hex7 = 7'b1000010;
            4'hE:    hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    assign tick       = &presc;
    assign boundary   = tick && (idx == LAST_IDX);
    assign frame_done = boundary;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (tick) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Commit reads the pre-edge shadow, so a load on the boundary cycle waits one frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pending    <= 1'b0;
        end else begin
            if (boundary && pending) begin
                act_digits <= sh_digits;
                act_dp     <= sh_dp;
                act_blank  <= sh_blank;
            end
            if (load) begin
                sh_digits <= digits;
                sh_dp     <= dp_in;
                sh_blank  <= blank;
                pending   <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib[k] = act_digits[4*k +: 4];
        end
    end

`ifdef SSEG_LZ_BLANK_EN
    logic lz_run;

    // Suppress from the top digit down until a nonzero or dp-lit digit; digit 0 always shows.
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            if (lz_run && (nib[k] == 4'h0) && !act_dp[k]) begin
                lz_mask[k] = 1'b1;
            end else begin
                lz_run = 1'b0;
            end
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign dark    = act_blank | lz_mask;
    assign cur_nib = nib[idx];

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sseg <= 7'b1111111;
            dp   <= 1'b1;
            an   <= AN_OFF;
        end else if (dark[idx]) begin
            sseg <= 7'b1111111;
            dp   <= 1'b1;
            an   <= AN_OFF;
        end else begin
            sseg <= hex7(cur_nib);
            dp   <= ~act_dp[idx];
            an   <= onehot ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - scoreboard bench for sseg_scan_driver (4 digits, 4-clk scan tick)
module tb_sseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        load;
    logic        pending;
    logic [0:6]  sseg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sseg;
        logic       dp;
    } slot_t;

    slot_t sb[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    sseg_scan_driver #(
        .NUM_DIGITS(4),
        .DIV_BITS  (2),
        .AN_ACT_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits    (digits),
        .dp_in     (dp_in),
        .blank     (blank),
        .load      (load),
        .pending   (pending),
        .sseg      (sseg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    function automatic slot_t lit_slot(input int k, input logic [3:0] n, input logic dpl);
        slot_t s;
        s.an   = ~(4'b0001 << k);
        s.sseg = glyph(n);
        s.dp   = ~dpl;
        return s;
    endfunction

    function automatic slot_t dark_slot();
        slot_t s;
        s.an   = 4'b1111;
        s.sseg = 7'b1111111;
        s.dp   = 1'b1;
        return s;
    endfunction

    task automatic push_frame(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
        for (int k = 0; k < 4; k++) begin
            if (bl[k]) sb.push_back(dark_slot());
            else       sb.push_back(lit_slot(k, d[4*k +: 4], dpv[k]));
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
        digits = d;
        dp_in  = dpv;
        blank  = bl;
        load   = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic wait_frame_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 64);
        tests_run++;
        if (frame_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_frame_done: no pulse within %0d cycles", tag, n);
        end
    endtask

    task automatic pop_compare(input string name);
        slot_t e;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: scoreboard empty, got an=%b sseg=%b dp=%b", name, an, sseg, dp);
        end else begin
            e = sb.pop_front();
            if (an !== e.an || sseg !== e.sseg || dp !== e.dp) begin
                tests_failed++;
                $display("FAIL %s: got an=%b sseg=%b dp=%b, expected an=%b sseg=%b dp=%b",
                         name, an, sseg, dp, e.an, e.sseg, e.dp);
            end
        end
    endtask

    // Entered at a frame_done negedge or just after the boundary edge; leaves at the next one.
    task automatic sample_frame(input string tag);
        for (int k = 0; k < 4; k++) begin
            skip((k == 0) ? 3 : 4);
            pop_compare($sformatf("%s_slot%0d", tag, k));
        end
        skip(1);
        tests_run++;
        if (frame_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_frame_period: frame_done=%b, expected 1 16 clk after previous", tag, frame_done);
        end
    endtask

    task automatic test_reset;
        int n;
        rst    = 1'b1;
        load   = 1'b0;
        digits = '0;
        dp_in  = '0;
        blank  = '0;
        skip(3);
        tests_run++;
        if (sseg !== 7'h7F || an !== 4'hF || dp !== 1'b1 || pending !== 1'b0 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: sseg=%b an=%b dp=%b pending=%b fd=%b, expected 1111111 1111 1 0 0",
                     sseg, an, dp, pending, frame_done);
        end
        rst = 1'b0;
        do_load(16'h1234, 4'h0, 4'h0);
        skip(6);
        tests_run++;
        if (pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_pre_pending: pending=%b, expected 1", pending);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (sseg !== 7'h7F || an !== 4'hF || dp !== 1'b1 || pending !== 1'b0 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: sseg=%b an=%b dp=%b pending=%b fd=%b, expected 1111111 1111 1 0 0",
                     sseg, an, dp, pending, frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n = 1;
        tests_run++;
        if (an !== 4'b1110 || sseg !== 7'b0000001 || dp !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_idx0: an=%b sseg=%b dp=%b, expected 1110 0000001 1", an, sseg, dp);
        end
        while (frame_done !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n != 15) begin
            tests_failed++;
            $display("FAIL reset_first_frame: frame_done after %0d clk, expected 15", n);
        end
    endtask

    task automatic test_scan;
        do_load(16'h1234, 4'h0, 4'h0);
        wait_frame_done("scan");
        tests_run++;
        if (pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL scan_pending: pending=%b, expected 1 before commit", pending);
        end
        push_frame(16'h1234, 4'h0, 4'h0);
        sample_frame("scan");
        tests_run++;
        if (pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL scan_pending_clear: pending=%b, expected 0", pending);
        end
    endtask

    task automatic test_tear_free;
        push_frame(16'h1234, 4'h0, 4'h0);
        skip(3);
        pop_compare("tear_old_slot0");
        do_load(16'hABCD, 4'h0, 4'h0);
        tests_run++;
        if (pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL tear_pending_set: pending=%b, expected 1", pending);
        end
        for (int k = 1; k < 4; k++) begin
            skip(4);
            pop_compare($sformatf("tear_old_slot%0d", k));
        end
        skip(1);
        tests_run++;
        if (frame_done !== 1'b1 || pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL tear_boundary: fd=%b pending=%b, expected 1 1", frame_done, pending);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL tear_pending_drop: pending=%b, expected 0 after boundary", pending);
        end
        push_frame(16'hABCD, 4'h0, 4'h0);
        sample_frame("tear_new");
    endtask

    task automatic test_collision;
        skip(3);
        do_load(16'h1111, 4'h0, 4'h0);
        wait_frame_done("coll");
        tests_run++;
        if (pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL coll_pre_pending: pending=%b, expected 1", pending);
        end
        do_load(16'h5555, 4'h0, 4'h0);
        tests_run++;
        if (pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL coll_pending_kept: pending=%b, expected 1", pending);
        end
        push_frame(16'h1111, 4'h0, 4'h0);
        sample_frame("coll_first");
        tests_run++;
        if (pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL coll_still_pending: pending=%b, expected 1", pending);
        end
        push_frame(16'h5555, 4'h0, 4'h0);
        sample_frame("coll_second");
        @(posedge clk);
        #1;
        tests_run++;
        if (pending !== 1'b0) begin
            tests_failed++;
            $display("FAIL coll_pending_final: pending=%b, expected 0", pending);
        end
    endtask

    task automatic test_back_to_back;
        do_load(16'h1357, 4'h0, 4'h0);
        do_load(16'hF08E, 4'h0, 4'h0);
        wait_frame_done("b2b");
        push_frame(16'hF08E, 4'h0, 4'h0);
        sample_frame("b2b");
    endtask

    task automatic test_blank_dp;
        do_load(16'h9876, 4'b0001, 4'b0100);
        wait_frame_done("blank");
        sb.push_back(lit_slot(0, 4'h6, 1'b1));
        sb.push_back(lit_slot(1, 4'h7, 1'b0));
        sb.push_back(dark_slot());
        sb.push_back(lit_slot(3, 4'h9, 1'b0));
        sample_frame("blank");
    endtask

    task automatic test_leading_zero;
        do_load(16'h0070, 4'h0, 4'h0);
        wait_frame_done("lz70");
`ifdef SSEG_LZ_BLANK_EN
        sb.push_back(lit_slot(0, 4'h0, 1'b0));
        sb.push_back(lit_slot(1, 4'h7, 1'b0));
        sb.push_back(dark_slot());
        sb.push_back(dark_slot());
`else
        push_frame(16'h0070, 4'h0, 4'h0);
`endif
        sample_frame("lz70");
        do_load(16'h0000, 4'h0, 4'h0);
        wait_frame_done("lz00");
`ifdef SSEG_LZ_BLANK_EN
        sb.push_back(lit_slot(0, 4'h0, 1'b0));
        sb.push_back(dark_slot());
        sb.push_back(dark_slot());
        sb.push_back(dark_slot());
`else
        push_frame(16'h0000, 4'h0, 4'h0);
`endif
        sample_frame("lz00");
        do_load(16'h0005, 4'b0100, 4'h0);
        wait_frame_done("lzdp");
`ifdef SSEG_LZ_BLANK_EN
        sb.push_back(lit_slot(0, 4'h5, 1'b0));
        sb.push_back(lit_slot(1, 4'h0, 1'b0));
        sb.push_back(lit_slot(2, 4'h0, 1'b1));
        sb.push_back(dark_slot());
`else
        push_frame(16'h0005, 4'b0100, 4'h0);
`endif
        sample_frame("lzdp");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_collision();
        test_back_to_back();
        test_blank_dp();
        test_leading_zero();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
